half_adder_checker: RTL

Synthesizable response checker for the half adder: the receiving and judging end of the stimulus stream that drives `half_adder`. Each accepted observation `{a, b, sum, carry}` is compared against the expected half-adder truth table. The block counts passes and failures, records which input combinations were seen, and captures the first failing observation. It then raises a verdict after a programmed number of samples. It sits beside the DUT in hardware self-test wrappers, replacing `$display`-based inspection with a registered pass/fail result.

---
 rtl/half_adder_checker.sv | 100 ++++++++++
 1 files changed

// File: rtl/half_adder_checker.sv
// Response checker for a half adder: judges each accepted {a,b,sum,carry}
// observation, keeps pass/fail counts and coverage, and raises a verdict after NUM_VECTORS samples.
module half_adder_checker #(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_sum,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [CNT_W-1:0] o_ok_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic [3:0]       o_coverage,
    output logic [3:0]       o_first_fail,
    output logic             o_first_fail_valid
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(NUM_VECTORS - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ok;
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_cov;
    logic [3:0]       r_ff;
    logic             r_ffv;

    logic w_run;
    logic w_hs;
    logic w_match;

    assign w_run   = (r_state == S_RUN);
    assign w_hs    = i_in_valid && w_run;
    assign w_match = (i_sum == (i_a ^ i_b)) && (i_carry == (i_a & i_b));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ok    <= '0;
            r_err   <= '0;
            r_cov   <= '0;
            r_ff    <= '0;
            r_ffv   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_ok    <= '0;
                        r_err   <= '0;
                        r_cov   <= '0;
                        r_ff    <= '0;
                        r_ffv   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_hs) begin
                        r_cnt            <= r_cnt + 1'b1;
                        r_cov[{i_a, i_b}] <= 1'b1;
                        if (w_match) begin
                            if (r_ok != '1) r_ok <= r_ok + 1'b1;
                        end else begin
                            if (r_err != '1) r_err <= r_err + 1'b1;
                            // Only the first mismatch of a run is kept
                            if (!r_ffv) begin
                                r_ff  <= {i_a, i_b, i_sum, i_carry};
                                r_ffv <= 1'b1;
                            end
                        end
                        if (r_cnt == LP_LAST) r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready         = w_run;
    assign o_busy             = w_run;
    assign o_done             = (r_state == S_DONE);
    assign o_pass             = o_done && (r_err == '0) && (r_cov == 4'b1111);
    assign o_ok_count         = r_ok;
    assign o_err_count        = r_err;
    assign o_coverage         = r_cov;
    assign o_first_fail       = r_ff;
    assign o_first_fail_valid = r_ffv;

endmodule
